// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU fetch/data request ports and memory array port of the arbiter
interface mem_port_arbiter_if #(parameter int ADDR_W = 5);
  logic              IF_REQ;
  logic [31:0]       IF_ADDR;
  logic [31:0]       IF_INST;
  logic              IF_ACK;
  logic              IF_ERR;
  logic              D_REQ;
  logic              D_WE;
  logic [1:0]        D_SIZE;
  logic              D_UNS;
  logic [31:0]       D_ADDR;
  logic [31:0]       D_WDATA;
  logic [31:0]       D_RDATA;
  logic              D_ACK;
  logic              D_ERR;
  logic              M_EN;
  logic              M_WE;
  logic [3:0]        M_BE;
  logic [ADDR_W-1:0] M_ADDR;
  logic [31:0]       M_WDATA;
  logic [31:0]       M_RDATA;
  logic              BUSY;
  modport slave (
    input  IF_REQ, IF_ADDR, D_REQ, D_WE, D_SIZE, D_UNS, D_ADDR, D_WDATA, M_RDATA,
    output IF_INST, IF_ACK, IF_ERR, D_RDATA, D_ACK, D_ERR, M_EN, M_WE, M_BE, M_ADDR, M_WDATA, BUSY
  );
  modport master (
    output IF_REQ, IF_ADDR, D_REQ, D_WE, D_SIZE, D_UNS, D_ADDR, D_WDATA, M_RDATA,
    input  IF_INST, IF_ACK, IF_ERR, D_RDATA, D_ACK, D_ERR, M_EN, M_WE, M_BE, M_ADDR, M_WDATA, BUSY
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data sharing of one sync-read word memory with lane select
module mem_port_arbiter #(parameter int ADDR_W = 5) (
  input logic CLK,
  input logic RST,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, gnt_q, gnt_d, we_q, we_d, uns_q, uns_d;
  logic [1:0] size_q, size_d, off_q, off_d;
  logic m_en_q, m_en_d, m_we_q, m_we_d;
  logic [3:0] m_be_q, m_be_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d, if_inst_q, if_inst_d, d_rdata_q, d_rdata_d;
  logic if_ack_q, if_ack_d, if_err_q, if_err_d, d_ack_q, d_ack_d, d_err_q, d_err_d, busy_q, busy_d;
  logic pick, req_err;
  logic [31:0] req_addr, ld;
  logic [1:0] req_size;
  logic [7:0] ld_b;
  logic [15:0] ld_h;
  logic unused_ok;
  // last_q=1 means data was served last, so fetch takes the next tie
  assign pick = bus.D_REQ & (~bus.IF_REQ | ~last_q);
  assign req_addr = pick ? bus.D_ADDR : bus.IF_ADDR;
  assign req_size = pick ? bus.D_SIZE : 2'd2;
  assign req_err = (req_size == 2'd3) | (req_size == 2'd2 & |req_addr[1:0]) | (req_size == 2'd1 & req_addr[0]);
  assign ld_b = bus.M_RDATA[{off_q, 3'b000} +: 8];
  assign ld_h = bus.M_RDATA[{off_q[1], 4'b0000} +: 16];
  assign ld = size_q == 2'd0 ? {{24{~uns_q & ld_b[7]}}, ld_b}
            : size_q == 2'd1 ? {{16{~uns_q & ld_h[15]}}, ld_h} : bus.M_RDATA;
  assign unused_ok = ^req_addr[31:ADDR_W+2];
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    gnt_d = gnt_q;
    we_d = we_q;
    uns_d = uns_q;
    size_d = size_q;
    off_d = off_q;
    m_en_d = 1'b0;
    m_we_d = 1'b0;
    m_be_d = '0;
    m_addr_d = '0;
    m_wdata_d = '0;
    if_inst_d = '0;
    if_ack_d = 1'b0;
    if_err_d = 1'b0;
    d_rdata_d = '0;
    d_ack_d = 1'b0;
    d_err_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.IF_REQ | bus.D_REQ) begin
        gnt_d = pick;
        last_d = pick;
        we_d = pick & bus.D_WE;
        uns_d = bus.D_UNS;
        size_d = req_size;
        off_d = req_addr[1:0];
        state_d = req_err ? RESP : ACCESS;
        d_ack_d = req_err & pick;
        d_err_d = req_err & pick;
        if_ack_d = req_err & ~pick;
        if_err_d = req_err & ~pick;
        m_en_d = ~req_err;
        m_we_d = ~req_err & we_d;
        m_addr_d = req_err ? '0 : req_addr[ADDR_W+1:2];
        m_be_d = req_err ? 4'h0 : ~we_d ? 4'hf
               : req_size == 2'd0 ? 4'b0001 << req_addr[1:0]
               : req_size == 2'd1 ? 4'b0011 << {req_addr[1], 1'b0} : 4'hf;
        m_wdata_d = (req_err | ~we_d) ? '0
                  : req_size == 2'd0 ? {4{bus.D_WDATA[7:0]}}
                  : req_size == 2'd1 ? {2{bus.D_WDATA[15:0]}} : bus.D_WDATA;
      end
      ACCESS: begin
        state_d = we_q ? RESP : CAPTURE;
        d_ack_d = we_q;
      end
      CAPTURE: begin
        state_d = RESP;
        d_ack_d = gnt_q;
        d_rdata_d = gnt_q ? ld : '0;
        if_ack_d = ~gnt_q;
        if_inst_d = gnt_q ? '0 : bus.M_RDATA;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      gnt_q <= 1'b0;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
      m_en_q <= 1'b0;
      m_we_q <= 1'b0;
      m_be_q <= '0;
      m_addr_q <= '0;
      m_wdata_q <= '0;
      if_inst_q <= '0;
      if_ack_q <= 1'b0;
      if_err_q <= 1'b0;
      d_rdata_q <= '0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      we_q <= we_d;
      uns_q <= uns_d;
      size_q <= size_d;
      off_q <= off_d;
      m_en_q <= m_en_d;
      m_we_q <= m_we_d;
      m_be_q <= m_be_d;
      m_addr_q <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      if_inst_q <= if_inst_d;
      if_ack_q <= if_ack_d;
      if_err_q <= if_err_d;
      d_rdata_q <= d_rdata_d;
      d_ack_q <= d_ack_d;
      d_err_q <= d_err_d;
      busy_q <= busy_d;
    end
  assign bus.M_EN = m_en_q;
  assign bus.M_WE = m_we_q;
  assign bus.M_BE = m_be_q;
  assign bus.M_ADDR = m_addr_q;
  assign bus.M_WDATA = m_wdata_q;
  assign bus.IF_INST = if_inst_q;
  assign bus.IF_ACK = if_ack_q;
  assign bus.IF_ERR = if_err_q;
  assign bus.D_RDATA = d_rdata_q;
  assign bus.D_ACK = d_ack_q;
  assign bus.D_ERR = d_err_q;
  assign bus.BUSY = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: random and directed transactions against a byte-level memory scoreboard
module tb_mem_port_arbiter;
  localparam int AW = 5;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  mem_port_arbiter_if #(.ADDR_W(AW)) bus();
  mem_port_arbiter #(.ADDR_W(AW)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  logic [31:0] mem [32];
  logic [31:0] ref_mem [32];
  int vectors = 0;
  int miscompares = 0;
  bit last_data = 1'b1;
  logic [31:0] f_addr, d_addr, d_wdata, acc_wdata, acc_rdata;
  logic [1:0] d_size;
  logic d_we, d_uns, acc_we;
  logic [3:0] acc_be;
  logic [AW-1:0] acc_maddr;
  int ports_q[$];
  always @(posedge CLK)
    if (bus.M_EN) begin
      if (bus.M_WE) begin
        for (int i = 0; i < 4; i++)
          if (bus.M_BE[i]) mem[bus.M_ADDR][8*i +: 8] <= bus.M_WDATA[8*i +: 8];
      end else bus.M_RDATA <= mem[bus.M_ADDR];
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic any_out();
    return |{bus.IF_INST, bus.IF_ACK, bus.IF_ERR, bus.D_RDATA, bus.D_ACK, bus.D_ERR,
             bus.M_EN, bus.M_WE, bus.M_BE, bus.M_ADDR, bus.M_WDATA, bus.BUSY};
  endfunction
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    logic [31:0] w, v;
    w = ref_mem[(a >> 2) % 32];
    if (sz == 2'd2) return w;
    v = (w >> (8 * (a % 4))) & (sz == 2'd0 ? 32'hFF : 32'hFFFF);
    if (!uns && sz == 2'd0 && v >= 128) v = v - 256;
    if (!uns && sz == 2'd1 && v >= 32768) v = v - 65536;
    return v;
  endfunction
  task automatic ref_store(input int nb);
    int idx, lane;
    idx = (d_addr >> 2) % 32;
    for (int j = 0; j < nb; j++) begin
      lane = int'(d_addr % 4) + j;
      ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << (8 * lane))) | (((d_wdata >> (8 * j)) & 32'hFF) << (8 * lane));
    end
  endtask
  task automatic serve(input bit p);
    logic [31:0] a, exp_data, exp_wd;
    logic [3:0] exp_be;
    int nb, lat, k, en_k;
    bit err, wr, got_ack, got_p, got_err, saw_en;
    a = p ? d_addr : f_addr;
    nb = p ? (1 << d_size) : 4;
    err = p ? (d_size == 2'd3 || (d_addr % nb) != 0) : ((f_addr % 4) != 0);
    wr = p && d_we && !err;
    lat = err ? 1 : wr ? 2 : 3;
    exp_data = (err || wr) ? 32'h0 : p ? ref_load(d_size, d_uns, d_addr) : ref_mem[(f_addr >> 2) % 32];
    exp_be = !wr ? 4'hf : 4'(((1 << nb) - 1) << (a % 4));
    exp_wd = !wr ? 32'h0 : nb == 1 ? (d_wdata & 32'hFF) * 32'h01010101
           : nb == 2 ? (d_wdata & 32'hFFFF) * 32'h00010001 : d_wdata;
    last_data = p;
    got_ack = 0; got_p = 0; got_err = 0; saw_en = 0; k = 0; en_k = 0;
    acc_rdata = '0;
    while (!got_ack && k < 8) begin
      @(posedge CLK); #1;
      k++;
      chk("dual_ack", 32'(bus.IF_ACK & bus.D_ACK), 0);
      if (bus.M_EN) begin
        saw_en = 1; en_k = k;
        acc_we = bus.M_WE; acc_be = bus.M_BE; acc_wdata = bus.M_WDATA; acc_maddr = bus.M_ADDR;
      end else chk("m_quiet", 32'(|{bus.M_WE, bus.M_BE, bus.M_WDATA}), 0);
      if (bus.IF_ACK || bus.D_ACK) begin
        got_ack = 1;
        got_p = bus.D_ACK;
        acc_rdata = got_p ? bus.D_RDATA : bus.IF_INST;
        got_err = got_p ? bus.D_ERR : bus.IF_ERR;
      end
    end
    chk("ack_seen", 32'(got_ack), 1);
    chk("ack_port", 32'(got_p), 32'(p));
    chk("latency", k, lat);
    chk("err", 32'(got_err), 32'(err));
    chk("rdata", acc_rdata, exp_data);
    chk("m_en_seen", 32'(saw_en), 32'(!err));
    if (!err) begin
      chk("en_cycle", en_k, 1);
      chk("m_addr", 32'(acc_maddr), (a >> 2) % 32);
      chk("m_we", 32'(acc_we), 32'(wr));
      chk("m_be", 32'(acc_be), 32'(exp_be));
      chk("m_wdata", acc_wdata, exp_wd);
    end
    if (wr) ref_store(nb);
    if (p) bus.D_REQ = 1'b0; else bus.IF_REQ = 1'b0;
    @(posedge CLK); #1;
    chk("ack_pulse", 32'(bus.IF_ACK | bus.D_ACK), 0);
    chk("idle_busy", 32'(bus.BUSY), 0);
    ports_q.push_back(int'(p));
  endtask
  task automatic run(input bit f_on, input bit d_on);
    bit first;
    bus.IF_ADDR = f_addr;
    bus.D_WE = d_we; bus.D_SIZE = d_size; bus.D_UNS = d_uns; bus.D_ADDR = d_addr; bus.D_WDATA = d_wdata;
    bus.IF_REQ = f_on;
    bus.D_REQ = d_on;
    first = (f_on && d_on) ? !last_data : d_on;
    serve(first);
    if (f_on && d_on) serve(!first);
  endtask
  task automatic data_op(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [31:0] wd);
    d_we = we; d_size = sz; d_uns = uns; d_addr = a; d_wdata = wd;
    run(1'b0, 1'b1);
  endtask
  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[4] = 32'h80202031;
    ref_mem[4] = 32'h80202031;
    bus.M_RDATA = '0;
    bus.D_REQ = 0; bus.D_WE = 0; bus.D_SIZE = 0; bus.D_UNS = 0; bus.D_ADDR = 0; bus.D_WDATA = 0;
    bus.IF_REQ = 1; bus.IF_ADDR = 0;
    repeat (3) @(posedge CLK);
    #1 chk("rst_outputs", 32'(any_out()), 0);
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;
    chk("rst_fetch_en", 32'(bus.M_EN), 1);
    chk("rst_fetch_maddr", 32'(bus.M_ADDR), 0);
    @(posedge CLK); #1;
    chk("rst_fetch_cap", 32'(bus.IF_ACK), 0);
    @(posedge CLK); #1;
    chk("rst_fetch_ack", 32'(bus.IF_ACK), 1);
    chk("rst_fetch_inst", bus.IF_INST, ref_mem[0]);
    bus.IF_REQ = 1'b0;
    last_data = 1'b0;
    @(posedge CLK); #1;
    data_op(0, 2'd0, 1, 32'h10, 0); chk("lbu_10", acc_rdata, 32'h00000031);
    data_op(0, 2'd0, 0, 32'h13, 0); chk("lb_13", acc_rdata, 32'hFFFFFF80);
    data_op(0, 2'd1, 1, 32'h12, 0); chk("lhu_12", acc_rdata, 32'h00008020);
    data_op(0, 2'd1, 0, 32'h12, 0); chk("lh_12", acc_rdata, 32'hFFFF8020);
    data_op(0, 2'd2, 0, 32'h10, 0); chk("lw_10", acc_rdata, 32'h80202031);
    data_op(1, 2'd0, 0, 32'h11, 32'h000000AB);
    chk("sb_be", 32'(acc_be), 32'h2);
    chk("sb_wdata", acc_wdata, 32'hABABABAB);
    chk("sb_maddr", 32'(acc_maddr), 4);
    data_op(0, 2'd2, 0, 32'h10, 0); chk("lw_after_sb", acc_rdata, 32'h8020AB31);
    data_op(0, 2'd2, 0, 32'h12, 0); chk("lw_mis_data", acc_rdata, 0);
    data_op(0, 2'd3, 0, 32'h10, 0);
    f_addr = 32'h06; run(1'b1, 1'b0);
    data_op(0, 2'd2, 0, 32'h80, 0);
    chk("wrap_maddr", 32'(acc_maddr), 0);
    chk("wrap_data", acc_rdata, ref_mem[0]);
    ports_q.delete();
    f_addr = 32'h20; d_we = 0; d_size = 2'd2; d_uns = 0; d_addr = 32'h24;
    run(1'b1, 1'b1);
    run(1'b1, 1'b1);
    chk("rr_count", ports_q.size(), 4);
    for (int i = 0; i < ports_q.size(); i++) chk("rr_order", ports_q[i], i % 2);
    d_we = 0; d_size = 2'd2; d_addr = 32'h8;
    bus.D_WE = 0; bus.D_SIZE = 2'd2; bus.D_ADDR = 32'h8; bus.D_REQ = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("mid_busy", 32'(bus.BUSY), 1);
    RST = 1'b1;
    bus.D_REQ = 1'b0;
    #1 chk("mid_rst_outputs", 32'(any_out()), 0);
    repeat (3) begin
      @(posedge CLK); #1;
      chk("mid_rst_no_ack", 32'(bus.D_ACK | bus.IF_ACK), 0);
    end
    @(negedge CLK) RST = 1'b0;
    last_data = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_idle", 32'(bus.BUSY), 0);
    for (int n = 0; n < 60; n++) begin
      int m, nb;
      m = $urandom_range(0, 3);
      d_we = 1'($urandom_range(0, 1));
      d_size = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      d_uns = 1'($urandom_range(0, 1));
      d_wdata = $urandom;
      nb = 1 << d_size;
      d_addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) d_addr = d_addr & ~32'(nb - 1);
      f_addr = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) f_addr = f_addr & ~32'h3;
      run(m == 0 || m == 3, m != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
